// File: rtl/ioctl_region_loader_if.sv
// Memory-side request bus of the ROM region loader.
//   out_req    toggle; a change means a new request is presented
//   out_ack    toggle; equals out_req once the request is complete
//   out_region target region index
//   out_addr   word address relative to the region base
//   out_data   word data, byte lane k = bits 8k+7:8k
//   out_be     byte enables
// master: the loader (drives the request), slave: the memory controller.
interface ioctl_region_loader_if #(
    parameter int unsigned OUT_AW     = 23,
    parameter int unsigned WORD_BYTES = 2
) ();
    logic                    out_req;
    logic                    out_ack;
    logic [2:0]              out_region;
    logic [OUT_AW-1:0]       out_addr;
    logic [8*WORD_BYTES-1:0] out_data;
    logic [WORD_BYTES-1:0]   out_be;

    modport master (
        output out_req,
        output out_region,
        output out_addr,
        output out_data,
        output out_be,
        input  out_ack
    );

    modport slave (
        input  out_req,
        input  out_region,
        input  out_addr,
        input  out_data,
        input  out_be,
        output out_ack
    );
endinterface

// File: rtl/ioctl_region_loader.sv
// ROM download controller: maps the HPS ioctl byte stream onto NREG address
// regions, packs bytes into WORD_BYTES-wide words with byte enables, queues the
// words and hands them to the memory controller over a toggle req/ack bus.
//   clk_sys, reset_n     clock, asynchronous active-low reset
//   ioctl_download/wr    download active / byte strobe (rising edge = new byte)
//   ioctl_addr/dout      byte address / byte data
//   ioctl_wait           back-pressure to HPS while the queue is nearly full
//   mem                  request bus to the memory controller (master side)
//   rom_loaded           download finished and everything written
//   core_reset           game core reset, released RST_HOLD cycles after load
//   drop_cnt             saturating count of bytes matching no region
//   overflow             sticky: a word was pushed into a full queue
module ioctl_region_loader #(
    parameter int unsigned NREG       = 4,
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned OUT_AW     = 23,
    parameter int unsigned WORD_BYTES = 2,
    parameter logic [NREG*ADDR_W-1:0] REGION_BASE =
        {25'h0030000, 25'h0020000, 25'h0010000, 25'h0000000},
    parameter logic [NREG*ADDR_W-1:0] REGION_SIZE =
        {25'h0010000, 25'h0010000, 25'h0010000, 25'h0010000},
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RST_HOLD   = 65535
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [ADDR_W-1:0]     ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    output logic                  ioctl_wait,
    ioctl_region_loader_if.master mem,
    output logic                  rom_loaded,
    output logic                  core_reset,
    output logic [15:0]           drop_cnt,
    output logic                  overflow
);
    localparam int unsigned LB     = $clog2(WORD_BYTES);
    localparam int unsigned LANE_W = (LB == 0) ? 1 : LB;
    localparam int unsigned PW     = $clog2(FIFO_DEPTH);
    localparam int unsigned DW     = 8 * WORD_BYTES;

    // Edge detection
    logic wr_q, dl_q;
    logic accept, acc_hit, acc_miss, dl_rise;

    // Region match
    logic              hit;
    logic [2:0]        hit_region;
    logic [ADDR_W-1:0] hit_off;
    logic [OUT_AW-1:0] hit_word;
    logic [LANE_W-1:0] hit_lane;
    logic [WORD_BYTES-1:0] lane_be;
    logic [DW-1:0]     lane_mask, byte_rep;

    // Pack register
    logic                  pk_valid;
    logic [2:0]            pk_region;
    logic [OUT_AW-1:0]     pk_word;
    logic [DW-1:0]         pk_data;
    logic [WORD_BYTES-1:0] pk_be;
    logic pk_push, pk_start, pk_merge, pk_differs;

    // Queue and handshake
    logic [2:0]            fifo_region [FIFO_DEPTH];
    logic [OUT_AW-1:0]     fifo_word   [FIFO_DEPTH];
    logic [DW-1:0]         fifo_data   [FIFO_DEPTH];
    logic [WORD_BYTES-1:0] fifo_be     [FIFO_DEPTH];
    logic [PW:0]           wr_ptr, rd_ptr, count;
    logic                  fifo_full, fifo_empty;
    logic                  pending, idle, issue, pop, do_push, ovf_event;

    // Load completion
    logic        loading, load_done;
    logic [31:0] rst_cnt;

    assign accept   = ioctl_download && ioctl_wr && !wr_q;
    assign acc_hit  = accept && hit;
    assign acc_miss = accept && !hit;
    assign dl_rise  = ioctl_download && !dl_q;

    // Lowest matching index wins, so scan downwards and let later hits override.
    // Comparing the offset against the size avoids overflow of base+size.
    always_comb begin
        hit        = 1'b0;
        hit_region = 3'd0;
        hit_off    = '0;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if (REGION_SIZE[i*ADDR_W +: ADDR_W] != '0 &&
                ioctl_addr >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
                (ioctl_addr - REGION_BASE[i*ADDR_W +: ADDR_W]) <
                    REGION_SIZE[i*ADDR_W +: ADDR_W]) begin
                hit        = 1'b1;
                hit_region = 3'(i);
                hit_off    = ioctl_addr - REGION_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign hit_word = OUT_AW'(hit_off >> LB);
    assign hit_lane = LANE_W'(hit_off & ADDR_W'(WORD_BYTES - 1));

    always_comb begin
        lane_be   = WORD_BYTES'(1) << hit_lane;
        lane_mask = '0;
        for (int k = 0; k < int'(WORD_BYTES); k++) begin
            lane_mask[8*k +: 8] = {8{lane_be[k]}};
        end
    end
    assign byte_rep = {WORD_BYTES{ioctl_dout}};

    // A valid pack leaves when it is complete, when the download is no longer
    // active (partial flush), or when a byte for another word arrives.
    assign pk_differs = (pk_region != hit_region) || (pk_word != hit_word);
    assign pk_push    = pk_valid && ((pk_be == '1) || !ioctl_download ||
                                     (acc_hit && pk_differs));
    assign pk_start   = acc_hit && (!pk_valid || pk_push);
    assign pk_merge   = acc_hit && pk_valid && !pk_push;

    assign count      = wr_ptr - rd_ptr;
    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign ioctl_wait = (count >= (PW+1)'(FIFO_DEPTH - 1));

    // The head entry stays queued while in flight; it is popped on completion.
    assign idle      = (mem.out_req == mem.out_ack);
    assign pop       = idle && pending;
    assign issue     = idle && !pending && !fifo_empty;
    assign do_push   = pk_push && (!fifo_full || pop);
    assign ovf_event = pk_push && fifo_full && !pop;

    assign load_done = loading && !ioctl_download && !pk_valid && fifo_empty &&
                       idle && !pending;

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            fifo_region[wr_ptr[PW-1:0]] <= pk_region;
            fifo_word[wr_ptr[PW-1:0]]   <= pk_word;
            fifo_data[wr_ptr[PW-1:0]]   <= pk_data;
            fifo_be[wr_ptr[PW-1:0]]     <= pk_be;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q           <= 1'b0;
            dl_q           <= 1'b0;
            pk_valid       <= 1'b0;
            pk_region      <= 3'd0;
            pk_word        <= '0;
            pk_data        <= '0;
            pk_be          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pending        <= 1'b0;
            mem.out_req    <= 1'b0;
            mem.out_region <= 3'd0;
            mem.out_addr   <= '0;
            mem.out_data   <= '0;
            mem.out_be     <= '0;
            rom_loaded     <= 1'b0;
            core_reset     <= 1'b1;
            loading        <= 1'b0;
            rst_cnt        <= '0;
            drop_cnt       <= 16'd0;
            overflow       <= 1'b0;
        end else begin
            wr_q <= ioctl_wr;
            dl_q <= ioctl_download;

            if (pk_start) begin
                pk_valid  <= 1'b1;
                pk_region <= hit_region;
                pk_word   <= hit_word;
                pk_data   <= byte_rep & lane_mask;
                pk_be     <= lane_be;
            end else if (pk_merge) begin
                pk_data <= (pk_data & ~lane_mask) | (byte_rep & lane_mask);
                pk_be   <= pk_be | lane_be;
            end else if (pk_push) begin
                pk_valid <= 1'b0;
                pk_be    <= '0;
            end

            if (do_push) wr_ptr <= wr_ptr + 1'b1;

            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                pending <= 1'b0;
            end

            if (issue) begin
                mem.out_region <= fifo_region[rd_ptr[PW-1:0]];
                mem.out_addr   <= fifo_word[rd_ptr[PW-1:0]];
                mem.out_data   <= fifo_data[rd_ptr[PW-1:0]];
                mem.out_be     <= fifo_be[rd_ptr[PW-1:0]];
                mem.out_req    <= ~mem.out_req;
                pending        <= 1'b1;
            end

            // A byte accepted on the start cycle still counts after the clear.
            if (dl_rise) begin
                drop_cnt <= acc_miss ? 16'd1 : 16'd0;
                overflow <= ovf_event;
            end else begin
                if (acc_miss && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                if (ovf_event) overflow <= 1'b1;
            end

            if (ioctl_download) begin
                core_reset <= 1'b1;
                rst_cnt    <= '0;
                if (!dl_q) begin
                    rom_loaded <= 1'b0;
                    loading    <= 1'b1;
                end
            end else if (load_done) begin
                rom_loaded <= 1'b1;
                loading    <= 1'b0;
                if (RST_HOLD == 0) core_reset <= 1'b0;
                else               rst_cnt    <= RST_HOLD;
            end else if (rom_loaded && core_reset) begin
                // Counts RST_HOLD edges after rom_loaded rose, then releases.
                if (rst_cnt <= 32'd1) begin
                    core_reset <= 1'b0;
                    rst_cnt    <= '0;
                end else begin
                    rst_cnt <= rst_cnt - 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ioctl_region_loader.sv
// Directed bench for ioctl_region_loader (WORD_BYTES=2, FIFO_DEPTH=4, RST_HOLD=16).
// Regions: 0 @0x0 len 0x8000, 1 @0xE000 len 0x2000, 2 @0x10000 len 0x10000,
// 3 @0x1C000 len 0x8000 (overlaps region 2, which must win on the overlap).
module tb_ioctl_region_loader;
    localparam int unsigned NREG = 4;
    localparam int unsigned AW   = 25;
    localparam logic [NREG*AW-1:0] BASES =
        {25'h001C000, 25'h0010000, 25'h000E000, 25'h0000000};
    localparam logic [NREG*AW-1:0] SIZES =
        {25'h0008000, 25'h0010000, 25'h0002000, 25'h0008000};

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_dout = 8'd0;
    logic          ioctl_wait, rom_loaded, core_reset, overflow;
    logic [15:0]   drop_cnt;

    ioctl_region_loader_if #(.OUT_AW(23), .WORD_BYTES(2)) mem_if ();

    ioctl_region_loader #(
        .NREG(NREG), .ADDR_W(AW), .OUT_AW(23), .WORD_BYTES(2),
        .REGION_BASE(BASES), .REGION_SIZE(SIZES), .FIFO_DEPTH(4), .RST_HOLD(16)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .mem(mem_if), .rom_loaded(rom_loaded),
        .core_reset(core_reset), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Memory responder: acks 2 time units after a posedge unless held.
    logic        hold = 1'b1;
    int          cap_n = 0;
    logic [2:0]  cap_region [64];
    logic [22:0] cap_addr   [64];
    logic [15:0] cap_data   [64];
    logic [1:0]  cap_be     [64];

    initial begin
        mem_if.out_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #2;
            if (!reset_n) begin
                mem_if.out_ack = 1'b0;
            end else if (!hold && mem_if.out_req !== mem_if.out_ack) begin
                if (cap_n < 64) begin
                    cap_region[cap_n] = mem_if.out_region;
                    cap_addr[cap_n]   = mem_if.out_addr;
                    cap_data[cap_n]   = mem_if.out_data;
                    cap_be[cap_n]     = mem_if.out_be;
                end
                cap_n = cap_n + 1;
                mem_if.out_ack = mem_if.out_req;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d);
        int n = 0;
        while (ioctl_wait && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        if (ioctl_wait) chk("wait_timeout", 32'(ioctl_wait), 32'd0);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic wait_caps(input int n);
        int k = 0;
        while (cap_n < n && k < 200) begin
            @(negedge clk_sys);
            k++;
        end
        chk("cap_count", 32'(cap_n), 32'(n));
    endtask

    task automatic chk_cap(input int i, input logic [2:0] r, input logic [22:0] a,
                           input logic [15:0] d, input logic [1:0] be);
        chk($sformatf("cap%0d_region", i), 32'(cap_region[i]), 32'(r));
        chk($sformatf("cap%0d_addr", i), 32'(cap_addr[i]), 32'(a));
        chk($sformatf("cap%0d_data", i), 32'(cap_data[i]), 32'(d));
        chk($sformatf("cap%0d_be", i), 32'(cap_be[i]), 32'(be));
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_out_req", 32'(mem_if.out_req), 32'd0);
        chk("rst_out_data", 32'(mem_if.out_data), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_rom_loaded", 32'(rom_loaded), 32'd0);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Two bytes complete one word; out_req toggles two edges after byte 2
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        send_byte(25'h0, 8'h11);
        send_byte(25'h1, 8'h22);
        chk("t1_req_before", 32'(mem_if.out_req), 32'd0);
        @(negedge clk_sys);
        chk("t1_req_toggled", 32'(mem_if.out_req), 32'd1);
        chk("t1_region", 32'(mem_if.out_region), 32'd0);
        chk("t1_addr", 32'(mem_if.out_addr), 32'd0);
        chk("t1_data", 32'(mem_if.out_data), 32'h2211);
        chk("t1_be", 32'(mem_if.out_be), 32'h3);
        hold = 1'b0;
        wait_caps(1);

        // Partial word flushed at end of download, then load done and reset hold
        send_byte(25'hE001, 8'h5A);
        ioctl_download = 1'b0;
        wait_caps(2);
        chk_cap(1, 3'd1, 23'h0, 16'h5A00, 2'b10);
        n = 0;
        while (!rom_loaded && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        chk("t2_loaded_latency", 32'(n), 32'd2);
        chk("t2_core_reset_held", 32'(core_reset), 32'd1);
        n = 0;
        while (core_reset && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        chk("t2_core_reset_hold", 32'(n), 32'd16);

        // New download: flags clear, misses count, region boundaries, overlap
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        chk("t3_rom_loaded_clr", 32'(rom_loaded), 32'd0);
        chk("t3_core_reset_set", 32'(core_reset), 32'd1);
        send_byte(25'h8000, 8'hEE);
        chk("t3_drop1", 32'(drop_cnt), 32'd1);
        send_byte(25'hDFFF, 8'hEF);
        chk("t3_drop2", 32'(drop_cnt), 32'd2);
        repeat (4) @(negedge clk_sys);
        chk("t3_no_req", 32'(cap_n), 32'd2);
        send_byte(25'h7FFF, 8'h77);
        send_byte(25'h1C000, 8'hC0);
        send_byte(25'h20001, 8'h33);
        send_byte(25'h20001, 8'h44);
        send_byte(25'h20000, 8'h55);
        wait_caps(5);
        chk_cap(2, 3'd0, 23'h3FFF, 16'h7700, 2'b10);
        chk_cap(3, 3'd2, 23'h6000, 16'h00C0, 2'b01);
        chk_cap(4, 3'd3, 23'h2000, 16'h4455, 2'b11);

        // Held ack: ioctl_wait at count 3, then drain in order
        hold = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(25'h100 + 25'(i), 8'hA0 + 8'(i));
        chk("t4_wait_cnt2", 32'(ioctl_wait), 32'd0);
        for (int i = 4; i < 6; i++) send_byte(25'h100 + 25'(i), 8'hA0 + 8'(i));
        chk("t4_wait_cnt3", 32'(ioctl_wait), 32'd1);
        repeat (5) @(negedge clk_sys);
        chk("t4_wait_held", 32'(ioctl_wait), 32'd1);
        chk("t4_no_cap_held", 32'(cap_n), 32'd5);
        hold = 1'b0;
        for (int i = 6; i < 10; i++) send_byte(25'h100 + 25'(i), 8'hA0 + 8'(i));
        wait_caps(10);
        for (int k = 0; k < 5; k++)
            chk_cap(5 + k, 3'd0, 23'h80 + 23'(k), 16'hA1A0 + 16'(k * 16'h0202), 2'b11);
        chk("t4_overflow", 32'(overflow), 32'd0);
        ioctl_download = 1'b0;
        n = 0;
        while (!rom_loaded && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        chk("t4_rom_loaded", 32'(rom_loaded), 32'd1);
        chk("t4_drop_kept", 32'(drop_cnt), 32'd2);

        // Asynchronous reset mid-stream; the queue is not resumed
        ioctl_download = 1'b1;
        hold = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < 4; i++) send_byte(25'h200 + 25'(i), 8'h10 + 8'(i));
        chk("t6_req_pending", 32'(mem_if.out_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_req", 32'(mem_if.out_req), 32'd0);
        chk("t6_async_core_reset", 32'(core_reset), 32'd1);
        chk("t6_async_wait", 32'(ioctl_wait), 32'd0);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        hold = 1'b0;
        repeat (20) @(negedge clk_sys);
        chk("t6_no_resume", 32'(cap_n), 32'd10);
        chk("t6_req_idle", 32'(mem_if.out_req), 32'd0);
        chk("t6_rom_loaded", 32'(rom_loaded), 32'd0);
        chk("t6_core_reset", 32'(core_reset), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ioctl_region_loader.md
Name: ioctl_region_loader

Overview:
- Parametrised successor to the top-level ROM download controller.
- Takes the HPS ioctl byte stream and maps each byte into one of NREG address regions (CPU, sound, sprite, tile ROMs).
- Packs bytes into WORD_BYTES-wide words with byte enables, queues them in a FIFO and issues them to the memory controller over a toggle req/ack handshake.
- Back-pressures HPS via ioctl_wait and generates rom_loaded plus a delayed core reset.

Parameters:
- NREG, 4, number of regions (1..8).
- ADDR_W, 25, ioctl byte address width.
- OUT_AW, 23, output word address width.
- WORD_BYTES, 2, bytes per output word (1, 2 or 4).
- REGION_BASE, packed NREG*ADDR_W, region i start byte address in slice i.
- REGION_SIZE, packed NREG*ADDR_W, region i length in bytes; 0 disables region i.
- FIFO_DEPTH, 4, output queue entries (power of 2, >=2).
- RST_HOLD, 65535, extra reset cycles after load completes.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  async active-low reset
- ioctl_download  in  1  download active
- ioctl_wr  in  1  byte strobe
- ioctl_addr  in  ADDR_W  byte address
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  back-pressure to HPS
- out_req  out  1  toggle; a change means a new request
- out_ack  in  1  toggle; equals out_req when the request is done
- out_region  out  3  target region index
- out_addr  out  OUT_AW  word address relative to region base
- out_data  out  8*WORD_BYTES  word data; byte lane k = bits 8k+7:8k
- out_be  out  WORD_BYTES  byte enables
- rom_loaded  out  1  all regions written, queue drained
- core_reset  out  1  active-high reset for the game core
- drop_cnt  out  16  bytes matching no region, saturating
- overflow  out  1  sticky; a push was attempted into a full FIFO

Behaviour:
- Reset state (reset_n low, asynchronous):
  - outputs and registers: out_req=0, out_region/out_addr/out_data/out_be=0, ioctl_wait=0, rom_loaded=0, core_reset=1, drop_cnt=0, overflow=0; FIFO empty; pack register invalid.
  - The memory side must also reset its out_ack to 0.
- Byte accept:
  - A byte is accepted on the cycle ioctl_wr is high and was low the previous cycle (rising-edge detect), only while ioctl_download=1.
  - Region match: BASE_i <= addr < BASE_i+SIZE_i. The lowest matching index wins.
  - No match: byte dropped, drop_cnt++ (saturates at FFFF).
- Address arithmetic:
  - off = addr - BASE_i; word = off / WORD_BYTES (truncated to OUT_AW); lane = off % WORD_BYTES.
- Packing register (region, word, data, be, valid):
  - If valid and (region or word differs from the new byte), push the pack register into the FIFO and start a new pack in the same cycle.
  - Write the byte into its lane and set be[lane]. Rewriting a lane overwrites it.
  - When be becomes all ones, push on the next cycle and clear valid.
  - Falling edge of ioctl_download with valid set: flush the partial word with its be.
- FIFO and handshake:
  - ioctl_wait = (count >= FIFO_DEPTH-1).
  - Push into a full FIFO: the entry is discarded and overflow is set.
  - Issue: when idle (out_req == out_ack) and FIFO non-empty, load the head onto out_* and toggle out_req in the same edge.
  - out_* must stay stable until out_ack == out_req. Pop on the cycle that equality is first seen; the next issue is allowed one cycle later.
  - Latency: byte completing a word at edge t → pushed at t+1 → out_req toggles at t+2 if idle.
- Download start (rising edge of ioctl_download):
  - clear rom_loaded, drop_cnt, overflow; core_reset=1.
- Load done:
  - rom_loaded sets once download has fallen, pack is invalid, FIFO is empty and out_req == out_ack.
- core_reset:
  - high while ioctl_download=1 or rom_loaded=0.
  - After rom_loaded rises, held for RST_HOLD further cycles, then low.
  - A new download reasserts it immediately.
- Simultaneous events:
  - push and pop in the same cycle: count unchanged.
  - accept and end-of-download in the same cycle: the byte is packed, then flushed.
- Reset mid-operation: all state is lost; the queue is not resumed.

Test Plan:
- WORD_BYTES=2, region0 base 0: bytes 0x11@0, 0x22@1 → one request: region 0, addr 0, data 0x2211, be 11; out_req toggles 2 cycles after the second byte.
- Region1 base 0xE000: byte 0x5A@0xE001, then download ends → request: region 1, addr 0, data 0x5A00, be 10 (partial flush).
- Byte @ address in no region → no request, drop_cnt=1.
- Hold out_ack, stream 10 bytes → ioctl_wait asserts at count 3 (FIFO_DEPTH=4); release ack → all 5 words delivered in order, overflow=0.
- Complete download with RST_HOLD=16 → rom_loaded rises after the last ack; core_reset falls exactly 16 cycles later.
- reset_n low mid-stream → out_req=0, FIFO empty, core_reset=1 asynchronously.
